// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator behind a two-entry ready/valid
// pipe (output register plus skid register). The immediate, its format
// code, an illegal flag and a sideband tag are delivered one cycle after
// an instruction is accepted.
// Optional feature macro: IMM_GEN_ILLEGAL_CNT_EN adds a saturating 16-bit
// count of illegal results accepted downstream on illegal_cnt_o.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    ,
    output logic [15:0]      illegal_cnt_o
`endif
);

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5,
        FMT_ZIMM = 3'd6,
        FMT_ILL  = 3'd7
    } immFmt_e;

    logic [XLEN-1:0]  decImm;
    immFmt_e          decFmt;
    logic             decIllegal;

    logic             outValid_q,   outValid_d;
    logic [XLEN-1:0]  outImm_q,     outImm_d;
    logic [2:0]       outFmt_q,     outFmt_d;
    logic             outIllegal_q, outIllegal_d;
    logic [TAG_W-1:0] outTag_q,     outTag_d;

    logic             skidValid_q,   skidValid_d;
    logic [XLEN-1:0]  skidImm_q,     skidImm_d;
    logic [2:0]       skidFmt_q,     skidFmt_d;
    logic             skidIllegal_q, skidIllegal_d;
    logic [TAG_W-1:0] skidTag_q,     skidTag_d;

    logic             accept;
    logic             outFree;

    // Decode the opcode and build the sign/zero-extended immediate at XLEN
    always_comb begin
        decImm     = '0;
        decFmt     = FMT_NONE;
        decIllegal = 1'b0;
        case (inst_i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                decImm = XLEN'($signed(inst_i[31:20]));
                decFmt = FMT_I;
            end
            7'b0100011: begin
                decImm = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
                decFmt = FMT_S;
            end
            7'b1100011: begin
                decImm = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                        inst_i[11:8], 1'b0}));
                decFmt = FMT_B;
            end
            7'b1101111: begin
                decImm = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                        inst_i[30:21], 1'b0}));
                decFmt = FMT_J;
            end
            7'b0110111, 7'b0010111: begin
                decImm = XLEN'($signed({inst_i[31:12], 12'h000}));
                decFmt = FMT_U;
            end
            7'b0110011, 7'b0001111: begin
                decImm = '0;
                decFmt = FMT_NONE;
            end
            7'b1110011: begin
                decImm = XLEN'(inst_i[19:15]);
                decFmt = FMT_ZIMM;
            end
            default: begin
                decImm     = '1;
                decFmt     = FMT_ILL;
                decIllegal = 1'b1;
            end
        endcase
    end

    // Ready depends only on the skid flop, so no path from out_ready_i
    assign in_ready_o = !skidValid_q;
    assign accept     = in_valid_i && !skidValid_q;
    assign outFree    = !outValid_q || out_ready_i;

    // Steer accepted results into the output or skid register, refill from skid on drain
    always_comb begin
        outValid_d    = outValid_q;
        outImm_d      = outImm_q;
        outFmt_d      = outFmt_q;
        outIllegal_d  = outIllegal_q;
        outTag_d      = outTag_q;
        skidValid_d   = skidValid_q;
        skidImm_d     = skidImm_q;
        skidFmt_d     = skidFmt_q;
        skidIllegal_d = skidIllegal_q;
        skidTag_d     = skidTag_q;
        if (outFree) begin
            if (skidValid_q) begin
                outValid_d   = 1'b1;
                outImm_d     = skidImm_q;
                outFmt_d     = skidFmt_q;
                outIllegal_d = skidIllegal_q;
                outTag_d     = skidTag_q;
                skidValid_d  = 1'b0;
            end else if (accept) begin
                outValid_d   = 1'b1;
                outImm_d     = decImm;
                outFmt_d     = decFmt;
                outIllegal_d = decIllegal;
                outTag_d     = tag_i;
            end else begin
                outValid_d   = 1'b0;
            end
        end else if (accept) begin
            skidValid_d   = 1'b1;
            skidImm_d     = decImm;
            skidFmt_d     = decFmt;
            skidIllegal_d = decIllegal;
            skidTag_d     = tag_i;
        end
    end

    // Pipe registers with synchronous active-low reset that discards in-flight entries
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outValid_q    <= 1'b0;
            outImm_q      <= '0;
            outFmt_q      <= FMT_NONE;
            outIllegal_q  <= 1'b0;
            outTag_q      <= '0;
            skidValid_q   <= 1'b0;
            skidImm_q     <= '0;
            skidFmt_q     <= FMT_NONE;
            skidIllegal_q <= 1'b0;
            skidTag_q     <= '0;
        end else begin
            outValid_q    <= outValid_d;
            outImm_q      <= outImm_d;
            outFmt_q      <= outFmt_d;
            outIllegal_q  <= outIllegal_d;
            outTag_q      <= outTag_d;
            skidValid_q   <= skidValid_d;
            skidImm_q     <= skidImm_d;
            skidFmt_q     <= skidFmt_d;
            skidIllegal_q <= skidIllegal_d;
            skidTag_q     <= skidTag_d;
        end
    end

    assign out_valid_o = outValid_q;
    assign imm_o       = outImm_q;
    assign fmt_o       = outFmt_q;
    assign illegal_o   = outIllegal_q;
    assign tag_o       = outTag_q;

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    logic [15:0] illegalCnt_q, illegalCnt_d;

    // Count illegal results as they leave, holding at the top value
    always_comb begin
        illegalCnt_d = illegalCnt_q;
        if (outValid_q && out_ready_i && outIllegal_q && (illegalCnt_q != 16'hFFFF)) begin
            illegalCnt_d = illegalCnt_q + 16'd1;
        end
    end

    // Counter register, cleared by reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            illegalCnt_q <= 16'd0;
        end else begin
            illegalCnt_q <= illegalCnt_d;
        end
    end

    assign illegal_cnt_o = illegalCnt_q;
`endif

endmodule
